myproject_mac_pipe: RTL and testbench
=====================================

Name: myproject_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate unit for the pruned CNN datapath. It is the successor to the combinational mul_Ns_Mns primitives.
- Configurable operand widths, din1 signedness and multiplier pipeline depth.
- Accumulates a stream of products into a dot-product result, framed by a last flag.
- Sits between the weight/activation feeders and the bias/activation stage.
- One result per frame; clock-enable stall compatible with the HLS ap_ce convention.

Parameters:
ID, 1, instance tag, no functional effect
NUM_STAGE, 2, multiplier pipeline registers (>=1)
din0_WIDTH, 16, signed activation width
din1_WIDTH, 10, weight width
DIN1_SIGNED, 0, 1 = din1 signed; 0 = din1 zero-extended (unsigned)
ACC_WIDTH, 32, accumulator width (>= product width)
OUT_SHIFT, 10, arithmetic right shift applied to accumulator before output
dout_WIDTH, 16, result width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ce  in  1  clock enable; 0 freezes all state
in_valid  in  1  din0/din1 pair valid this cycle
in_last  in  1  qualifies final pair of a frame (sampled with in_valid)
din0  in  din0_WIDTH  signed activation
din1  in  din1_WIDTH  weight, signedness per DIN1_SIGNED
out_valid  out  1  dout valid, single-cycle pulse
dout  out  dout_WIDTH  frame result
ovf  out  1  sticky; accumulator wrapped or result out of range in current frame, valid with out_valid

Behaviour:
- Reset: one clk edge with reset=1 clears the valid/last pipeline, accumulator, out_valid, dout and ovf to 0. Reset overrides ce. A frame in flight is discarded and produces no output.
- Product: P = signed(din0) * (DIN1_SIGNED ? signed(din1) : signed({1'b0,din1})).
  - P width is din0_WIDTH+din1_WIDTH+(DIN1_SIGNED?0:1).
  - P is sign-extended to ACC_WIDTH.
- Pipeline: P, valid and last advance through NUM_STAGE registers only when ce=1. Accumulate stage follows.
- Accumulate stage, when ce=1 and the stage-NUM_STAGE valid is set:
  - sum = acc + P.
  - If last=0: acc <= sum.
  - If last=1: result <= sum, acc <= 0, out_valid <= 1.
- Latency: in_valid&in_last at cycle t gives out_valid at t+NUM_STAGE+1, counted in ce=1 cycles only.
- Throughput: one pair per ce cycle. No backpressure; the consumer must accept every pulse.
- out_valid deasserts the cycle after the pulse when ce=1. When ce=0, out_valid and dout hold.
- Frame boundary: a new frame's first pair may follow in_last on the next cycle with no bubble. Bubbles (in_valid=0) inside a frame are allowed.
- Single-element frame (in_valid&in_last with no prior pairs): dout = P result.
- dout = bits [OUT_SHIFT+dout_WIDTH-1 : OUT_SHIFT] of the result (floor, two's-complement truncation).
- ovf sets when either occurs within the frame:
  - a signed add wraps ACC_WIDTH, or
  - result>>OUT_SHIFT falls outside the dout_WIDTH signed range.
- ovf clears when the next frame begins.
- in_last with in_valid=0 is ignored.

Optional Feature:
MYPROJECT_MAC_SAT_EN
- Defined: the shifted result is saturated to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1] instead of truncated. An accumulator add that would wrap clamps acc to the ACC_WIDTH signed extremes. ovf still reports the event.
- Undefined: wrap/truncate as above. No saturation logic is generated.

Decomposition:
- Package myproject_mac_pkg holds:
  - localparam function prod_width(din0_WIDTH, din1_WIDTH, DIN1_SIGNED);
  - sat/trunc helper functions;
  - the pipeline-stage struct typedef {valid, last, product}.
- One sub-module: myproject_mac_mul_pipe, covering the signed multiply plus the NUM_STAGE register chain with ce. It is reusable standalone as the pipelined successor of the plain multiplier.

Test Plan:
- Reset mid-frame: feed 3 pairs with no last, assert reset 1 cycle, then single pair din0=5,din1=3,last, with OUT_SHIFT=0 -> one out_valid, dout=15; the pre-reset pairs do not contribute.
- Unsigned weight: DIN1_SIGNED=0, din0=-2, din1=10'h3FF (1023), last, OUT_SHIFT=0 -> dout=-2046, ovf=0. With DIN1_SIGNED=1, din1=10'h3FF (-1) -> dout=2.
- Back-to-back frames: frame A {(1,2),(3,4)} then frame B {(5,6)} with no gap, OUT_SHIFT=0 -> pulses at consecutive valid boundaries, dout=14 then 30. Latency = NUM_STAGE+1 from each last.
- ce stall: in a 4-pair frame of (100,100) with OUT_SHIFT=0, drop ce for 3 cycles mid-frame -> result 40000 delivered exactly 3 cycles late. During the stall out_valid and dout hold.
- Overflow: dout_WIDTH=16, OUT_SHIFT=0, frame of 4 pairs (32767,1023) -> ovf=1. With MYPROJECT_MAC_SAT_EN, dout=32767; without it, dout equals the truncated low 16 bits of the sum.
- Shift rounding: OUT_SHIFT=10, single pair (-1,1) -> dout=-1 (floor), ovf=0.

Source files
------------

// File: rtl/myproject_mac_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate unit.
// The MYPROJECT_MAC_SAT_EN build uses mac_sat in place of mac_trunc.
package myproject_mac_pkg;

    localparam int MAC_PROD_MAX = 64;

    typedef struct packed {
        logic                           valid;
        logic                           last;
        logic signed [MAC_PROD_MAX-1:0] product;
    } mac_stage_t;

    function automatic int prod_width(input int din0_width, input int din1_width,
                                      input int din1_signed);
        return din0_width + din1_width + ((din1_signed != 0) ? 0 : 1);
    endfunction

    function automatic logic mac_fits(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic signed [63:0] mac_sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    // Keep the low w bits and re-extend their sign (two's-complement wrap).
    function automatic logic signed [63:0] mac_trunc(input logic signed [63:0] v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

endpackage

// File: rtl/myproject_mac_mul_pipe.sv
// Signed multiplier followed by a NUM_STAGE clock-enabled register chain
// carrying valid, last and the sign-extended product.
module myproject_mac_mul_pipe
    import myproject_mac_pkg::*;
#(
    parameter int NUM_STAGE   = 2,
    parameter int din0_WIDTH  = 16,
    parameter int din1_WIDTH  = 10,
    parameter int DIN1_SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output mac_stage_t            out_stage
);

    localparam int FULL_W = din0_WIDTH + din1_WIDTH + 1;

    logic signed [din1_WIDTH:0] din1_ext_s;
    logic signed [FULL_W-1:0]   prod_s;
    mac_stage_t                 stage_r [NUM_STAGE];

    // One extra weight bit lets a single signed multiplier serve both weight encodings
    always_comb begin
        if (DIN1_SIGNED != 0) begin
            din1_ext_s = {din1[din1_WIDTH-1], din1};
        end else begin
            din1_ext_s = {1'b0, din1};
        end
        prod_s = FULL_W'($signed(din0)) * FULL_W'(din1_ext_s);
    end

    // Stage register chain, frozen while ce is low
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                stage_r[i] <= '0;
            end
        end else if (ce) begin
            stage_r[0] <= '{valid:   in_valid,
                            last:    in_valid & in_last,
                            product: MAC_PROD_MAX'(prod_s)};
            for (int i = 1; i < NUM_STAGE; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_stage = stage_r[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiply-accumulate producing one scaled result per frame.
// Define MYPROJECT_MAC_SAT_EN to saturate the accumulator and the result.
module myproject_mac_pipe
    import myproject_mac_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 2,
    parameter int din0_WIDTH  = 16,
    parameter int din1_WIDTH  = 10,
    parameter int DIN1_SIGNED = 0,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_SHIFT   = 10,
    parameter int dout_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PROD_W = prod_width(din0_WIDTH, din1_WIDTH, DIN1_SIGNED);

    if (NUM_STAGE < 1 || ACC_WIDTH < PROD_W || ACC_WIDTH > MAC_PROD_MAX ||
        dout_WIDTH > MAC_PROD_MAX || ID < 0) begin : g_bad_params
        $error("myproject_mac_pipe: illegal parameter combination");
    end

`ifdef MYPROJECT_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    mac_stage_t                  pipe_s;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] prod_s;
    logic signed [ACC_WIDTH-1:0] sum_raw_s;
    logic signed [ACC_WIDTH-1:0] sum_s;
    logic signed [ACC_WIDTH-1:0] shifted_s;
    logic                        wrap_s;
    logic                        range_ok_s;
    logic                        ovf_frame_r;
    logic [dout_WIDTH-1:0]       dout_next_s;

    myproject_mac_mul_pipe #(
        .NUM_STAGE   (NUM_STAGE),
        .din0_WIDTH  (din0_WIDTH),
        .din1_WIDTH  (din1_WIDTH),
        .DIN1_SIGNED (DIN1_SIGNED)
    ) u_mul_pipe (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .din0      (din0),
        .din1      (din1),
        .out_stage (pipe_s)
    );

    // Add, wrap detection and output scaling for the pair leaving the multiplier pipe
    always_comb begin
        prod_s    = ACC_WIDTH'(pipe_s.product);
        sum_raw_s = acc_r + prod_s;
        wrap_s    = (acc_r[ACC_WIDTH-1] == prod_s[ACC_WIDTH-1]) &&
                    (sum_raw_s[ACC_WIDTH-1] != acc_r[ACC_WIDTH-1]);
`ifdef MYPROJECT_MAC_SAT_EN
        if (wrap_s) begin
            sum_s = acc_r[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_s = sum_raw_s;
        end
`else
        sum_s = sum_raw_s;
`endif
        shifted_s  = sum_s >>> OUT_SHIFT;
        range_ok_s = mac_fits(64'(shifted_s), dout_WIDTH);
`ifdef MYPROJECT_MAC_SAT_EN
        dout_next_s = dout_WIDTH'(mac_sat(64'(shifted_s), dout_WIDTH));
`else
        dout_next_s = dout_WIDTH'(mac_trunc(64'(shifted_s), dout_WIDTH));
`endif
    end

    // Accumulator, frame-sticky overflow and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r       <= '0;
            ovf_frame_r <= 1'b0;
            out_valid   <= 1'b0;
            dout        <= '0;
            ovf         <= 1'b0;
        end else if (ce) begin
            out_valid <= 1'b0;
            if (pipe_s.valid) begin
                if (pipe_s.last) begin
                    acc_r       <= '0;
                    ovf_frame_r <= 1'b0;
                    out_valid   <= 1'b1;
                    dout        <= dout_next_s;
                    ovf         <= ovf_frame_r | wrap_s | ~range_ok_s;
                end else begin
                    // A non-final pair means a frame is under way, so the previous report retires
                    acc_r       <= sum_s;
                    ovf_frame_r <= ovf_frame_r | wrap_s;
                    ovf         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Scoreboard bench: three configurations of myproject_mac_pipe share one
// directed stimulus stream; results are predicted when pairs are driven.
module tb_myproject_mac_pipe;

    localparam int NS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_last;
    logic [15:0] din0;
    logic [9:0]  din1;

    logic        ov_a, ov_b, ov_c;
    logic signed [15:0] do_a, do_b, do_c;
    logic        ovf_a, ovf_b, ovf_c;

    typedef struct packed {
        int              edge_idx;
        logic [2:0][15:0] d;
        logic [2:0]      o;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     ce_edges = 0;
    bit     last_ce  = 1'b0;
    int     checks   = 0;
    int     passed   = 0;
    longint m_acc[3];
    bit     m_ovf[3];
    int     cfg_signed[3] = '{0, 1, 0};
    int     cfg_shift[3]  = '{0, 0, 10};

    always #5 clk = ~clk;

    myproject_mac_pipe #(.NUM_STAGE(NS), .DIN1_SIGNED(0), .OUT_SHIFT(0)) u_a (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov_a), .dout(do_a), .ovf(ovf_a));

    myproject_mac_pipe #(.NUM_STAGE(NS), .DIN1_SIGNED(1), .OUT_SHIFT(0)) u_b (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov_b), .dout(do_b), .ovf(ovf_b));

    myproject_mac_pipe #(.NUM_STAGE(NS), .DIN1_SIGNED(0), .OUT_SHIFT(10)) u_c (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov_c), .dout(do_c), .ovf(ovf_c));

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic longint wrap32(input longint v);
        logic signed [31:0] t;
        t = v[31:0];
        return longint'(t);
    endfunction

    task automatic model_pair(input int a, input int b, input bit l, input int edge_idx);
        exp_t   e;
        longint w, p, s, sh;
        bit     wr, oor;
        logic signed [15:0] d;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            w  = (cfg_signed[i] != 0 && b >= 512) ? longint'(b - 1024) : longint'(b);
            p  = longint'(a) * w;
            s  = m_acc[i] + p;
            wr = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef MYPROJECT_MAC_SAT_EN
            if (wr) s = (s > 0) ? 64'sd2147483647 : -64'sd2147483648;
`else
            s = wrap32(s);
`endif
            if (l) begin
                sh  = s >>> cfg_shift[i];
                oor = (sh > 64'sd32767) || (sh < -64'sd32768);
`ifdef MYPROJECT_MAC_SAT_EN
                d = (sh > 64'sd32767) ? 16'sd32767 : (sh < -64'sd32768) ? -16'sd32768 : sh[15:0];
`else
                d = sh[15:0];
`endif
                e.d[i]   = d;
                e.o[i]   = m_ovf[i] | wr | oor;
                m_acc[i] = 0;
                m_ovf[i] = 1'b0;
            end else begin
                m_acc[i] = s;
                m_ovf[i] = m_ovf[i] | wr;
            end
        end
        if (l) begin
            e.edge_idx = edge_idx + NS;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input bit v, input bit l, input int a, input int b, input bit c);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = v;
        in_last  = l;
        din0     = 16'(a);
        din1     = 10'(b);
        ce       = c;
        if (v && c) model_pair(a, b, l, ce_edges + 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        ce       = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    // Count enabled edges so latency is measured in ce cycles only
    always @(posedge clk) begin
        if (ce && !reset) ce_edges <= ce_edges + 1;
        last_ce <= ce && !reset;
    end

    // Compare each new output against the scoreboard and reject stray pulses
    always @(negedge clk) begin
        if (last_ce) begin
            if (exp_q.size() > 0 && exp_q[0].edge_idx == ce_edges) begin
                mon_e = exp_q.pop_front();
                chk("pulse_valid", {29'd0, ov_c, ov_b, ov_a}, 32'sd7);
                chk("dout_a", do_a, $signed(mon_e.d[0]));
                chk("dout_b", do_b, $signed(mon_e.d[1]));
                chk("dout_c", do_c, $signed(mon_e.d[2]));
                chk("ovf", {29'd0, ovf_c, ovf_b, ovf_a}, {29'd0, mon_e.o});
            end else begin
                chk("idle_valid", {29'd0, ov_c, ov_b, ov_a}, 32'sd0);
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; ce = 1'b0; in_valid = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        do_reset();
        do_reset();
        idle(1);
        chk("rst_valid", {29'd0, ov_c, ov_b, ov_a}, 32'sd0);
        chk("rst_dout_a", do_a, 32'sd0);
        chk("rst_dout_c", do_c, 32'sd0);
        chk("rst_ovf", {29'd0, ovf_c, ovf_b, ovf_a}, 32'sd0);

        // Frame cut by reset, then a fresh single-pair frame: 5*3
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 7, 7, 1'b1);
        do_reset();
        drive(1'b1, 1'b1, 5, 3, 1'b1);
        idle(4);

        // Weight 0x3FF: 1023 unsigned, -1 signed
        drive(1'b1, 1'b1, -2, 1023, 1'b1);
        idle(4);

        // Back-to-back frames {(1,2),(3,4)} then {(5,6)}
        drive(1'b1, 1'b0, 1, 2, 1'b1);
        drive(1'b1, 1'b1, 3, 4, 1'b1);
        drive(1'b1, 1'b1, 5, 6, 1'b1);
        idle(4);

        // Bubble inside a frame, carrying a last flag that must be ignored
        drive(1'b1, 1'b0, 2, 3, 1'b1);
        drive(1'b0, 1'b1, 99, 99, 1'b1);
        drive(1'b1, 1'b1, 4, 5, 1'b1);
        idle(4);

        // Three-cycle ce stall mid-frame; pairs offered while stalled are ignored
        drive(1'b1, 1'b0, 100, 100, 1'b1);
        drive(1'b1, 1'b0, 100, 100, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 77, 77, 1'b0);
        drive(1'b1, 1'b0, 100, 100, 1'b1);
        drive(1'b1, 1'b1, 100, 100, 1'b1);
        idle(4);

        // Output hold while ce is low during a pulse
        drive(1'b1, 1'b1, 9, 9, 1'b1);
        idle(2);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        chk("hold_valid", {29'd0, ov_c, ov_b, ov_a}, 32'sd7);
        chk("hold_dout_a", do_a, 32'sd81);
        chk("hold_dout_b", do_b, 32'sd81);
        idle(4);

        // Result out of dout range, then an accumulator wrap
        for (int i = 0; i < 4; i++) drive(1'b1, i == 3, 32767, 1023, 1'b1);
        idle(4);
        for (int i = 0; i < 70; i++) drive(1'b1, i == 69, 32767, 1023, 1'b1);
        idle(4);

        // Floor on the arithmetic shift
        drive(1'b1, 1'b1, -1, 1, 1'b1);
        idle(4);

        // Short random frames with random ce
        for (int f = 0; f < 8; f++) begin
            n = int'($urandom_range(1, 4));
            for (int j = 0; j < n; j++) begin
                drive(1'b1, j == n - 1, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 1023)), $urandom_range(0, 3) != 0);
            end
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
        idle(2);
        chk("drain", exp_q.size(), 32'sd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
